fixed_residual_add: RTL

Residual (skip-connection) stage that sits directly downstream of the self-attention block. It captures each input block on the shared input stream and holds it in a skip FIFO while attention computes. When the matching attention output block arrives, it adds the two element-wise, re-quantises the sum and saturates it to the output format. Blocks are matched strictly in arrival order; the stage emits one registered output block per matched pair.

---
 rtl/fixed_residual_pkg.sv | 39 +++
 rtl/fixed_block_fifo.sv | 53 +++++
 rtl/fixed_residual_add.sv | 86 ++++++++
 3 files changed

// File: rtl/fixed_residual_pkg.sv
// Shared definitions for the residual-add stage: default geometry, accumulator
// width and the shift-plus-saturate helper used by every adder lane.
package fixed_residual_pkg;

    localparam int DEF_PARALLELISM = 3;
    localparam int DEF_SIZE        = 3;
    localparam int DEF_N           = DEF_PARALLELISM * DEF_SIZE;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_PTR_W       = $clog2(DEF_DEPTH);
    localparam int ACC_W           = 32;

    // Re-scale value from in_frac to out_frac fractional bits (floor on right
    // shift), then clamp to the signed range of out_width bits.
    function automatic logic signed [ACC_W-1:0] fixed_align_sat(
        input logic signed [ACC_W-1:0] value,
        input int                      in_frac,
        input int                      out_frac,
        input int                      out_width
    );
        logic signed [ACC_W-1:0] shifted;
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        if (out_frac < in_frac) begin
            shifted = value >>> (in_frac - out_frac);
        end else begin
            shifted = value <<< (out_frac - in_frac);
        end
        max_v = (32'sd1 <<< (out_width - 1)) - 32'sd1;
        min_v = -(32'sd1 <<< (out_width - 1));
        if (shifted > max_v) begin
            fixed_align_sat = max_v;
        end else if (shifted < min_v) begin
            fixed_align_sat = min_v;
        end else begin
            fixed_align_sat = shifted;
        end
    endfunction

endpackage

// File: rtl/fixed_block_fifo.sv
// Block-wide synchronous FIFO with occupancy count; head entry is always
// visible on rd_data. Caller only pushes when not full and pops when not empty.
module fixed_block_fifo
    import fixed_residual_pkg::*;
#(
    parameter int WIDTH = DEF_N * 8,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; only the bookkeeping registers do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fixed_residual_add.sv
// Residual stage: buffers skip blocks, joins each with the next attention
// block in arrival order, adds, re-quantises, saturates and registers the result.
module fixed_residual_add
    import fixed_residual_pkg::*;
#(
    parameter int IN_WIDTH       = 8,
    parameter int IN_FRAC_WIDTH  = 1,
    parameter int ATT_WIDTH      = 8,
    parameter int ATT_FRAC_WIDTH = 1,
    parameter int OUT_WIDTH      = 8,
    parameter int OUT_FRAC_WIDTH = 1,
    parameter int PARALLELISM    = DEF_PARALLELISM,
    parameter int SIZE           = DEF_SIZE,
    parameter int DEPTH          = DEF_DEPTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [PARALLELISM*SIZE*IN_WIDTH-1:0]     data_in,
    input  logic                                     data_in_valid,
    output logic                                     data_in_ready,
    input  logic [PARALLELISM*SIZE*ATT_WIDTH-1:0]    att_in,
    input  logic                                     att_in_valid,
    output logic                                     att_in_ready,
    output logic [PARALLELISM*SIZE*OUT_WIDTH-1:0]    data_out,
    output logic                                     data_out_valid,
    input  logic                                     data_out_ready
);

    localparam int N     = PARALLELISM * SIZE;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int F     = (IN_FRAC_WIDTH > ATT_FRAC_WIDTH) ? IN_FRAC_WIDTH : ATT_FRAC_WIDTH;

    logic [N*IN_WIDTH-1:0]  skip_data;
    logic [N*OUT_WIDTH-1:0] sum_flat;
    logic [CNT_W-1:0]       count;
    logic                   push;
    logic                   pop;

    // Readies come from registered count and downstream ready only.
    assign data_in_ready = (count != CNT_W'(DEPTH));
    assign att_in_ready  = (count != '0) && (!data_out_valid || data_out_ready);
    assign push          = data_in_valid && data_in_ready;
    assign pop           = att_in_valid && att_in_ready;

    fixed_block_fifo #(
        .WIDTH (N * IN_WIDTH),
        .DEPTH (DEPTH)
    ) u_skip_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (data_in),
        .push    (push),
        .pop     (pop),
        .rd_data (skip_data),
        .count   (count)
    );

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [IN_WIDTH-1:0]  a;
        logic signed [ATT_WIDTH-1:0] b;
        logic signed [ACC_W-1:0]     a_al;
        logic signed [ACC_W-1:0]     b_al;
        logic signed [ACC_W-1:0]     s;

        assign a    = skip_data[i*IN_WIDTH +: IN_WIDTH];
        assign b    = att_in[i*ATT_WIDTH +: ATT_WIDTH];
        assign a_al = ACC_W'(a) <<< (F - IN_FRAC_WIDTH);
        assign b_al = ACC_W'(b) <<< (F - ATT_FRAC_WIDTH);
        assign s    = a_al + b_al;
        assign sum_flat[i*OUT_WIDTH +: OUT_WIDTH] =
            OUT_WIDTH'(fixed_align_sat(s, F, OUT_FRAC_WIDTH, OUT_WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else if (pop) begin
            data_out       <= sum_flat;
            data_out_valid <= 1'b1;
        end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end

endmodule
